logic_basic_queue_generic_capacity_tracker: RTL

Multi-beat occupancy tracker for generic queues. It supports a non-power-of-two capacity, variable write/read beat counts per cycle, saturating arithmetic and registered status flags (empty/full/almost). It also provides sticky overflow/underflow error flags and a synchronous flush. It sits beside queue storage and replaces the single-beat up/down counter where multi-beat ports or exact depths are needed.

---
 rtl/logic_basic_queue_generic_capacity_tracker.sv | 123 ++++++++++++
 1 files changed

// File: rtl/logic_basic_queue_generic_capacity_tracker.sv
// Multi-beat occupancy tracker for queues of arbitrary depth: saturating
// netted write/read arithmetic, registered status flags and sticky error flags.
module logic_basic_queue_generic_capacity_tracker #(
    parameter int CAPACITY     = 16,
    parameter int WRITE_MAX    = 1,
    parameter int READ_MAX     = 1,
    parameter int ALMOST_FULL  = CAPACITY - 1,
    parameter int ALMOST_EMPTY = 1,
    localparam int CAPACITY_WIDTH    = $clog2(CAPACITY + 1),
    localparam int WRITE_COUNT_WIDTH = $clog2(WRITE_MAX + 1),
    localparam int READ_COUNT_WIDTH  = $clog2(READ_MAX + 1)
) (
    input  logic                         aclk,
    input  logic                         areset_n,
    input  logic                         clear,
    input  logic                         write_enable,
    input  logic [WRITE_COUNT_WIDTH-1:0] write_count,
    input  logic                         read_enable,
    input  logic [READ_COUNT_WIDTH-1:0]  read_count,
    input  logic                         error_clear,
    output logic [CAPACITY_WIDTH-1:0]    capacity,
    output logic [CAPACITY_WIDTH-1:0]    free,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW       = CAPACITY_WIDTH;
    localparam int MAX_IN_W = (WRITE_COUNT_WIDTH > READ_COUNT_WIDTH) ? WRITE_COUNT_WIDTH : READ_COUNT_WIDTH;
    // Two extra bits keep the signed sum exact even for out-of-range counts.
    localparam int SUM_W    = ((CW > MAX_IN_W) ? CW : MAX_IN_W) + 2;

    localparam logic signed [SUM_W-1:0] CAP_SUM  = SUM_W'(CAPACITY);
    localparam logic [CW-1:0]           CAP_L    = CW'(CAPACITY);
    localparam logic [CW-1:0]           AF_L     = CW'(ALMOST_FULL);
    localparam logic [CW-1:0]           AE_L     = CW'(ALMOST_EMPTY);
    localparam logic                    AF_RESET = (ALMOST_FULL == 0) ? 1'b1 : 1'b0;

    logic [CW-1:0]           capacity_r;
    logic [CW-1:0]           free_r;
    logic                    empty_r;
    logic                    full_r;
    logic                    almost_empty_r;
    logic                    almost_full_r;
    logic                    overflow_r;
    logic                    underflow_r;

    logic signed [SUM_W-1:0] cur_s;
    logic signed [SUM_W-1:0] w_s;
    logic signed [SUM_W-1:0] r_s;
    logic signed [SUM_W-1:0] sum_s;
    logic [CW-1:0]           next_cap_s;
    logic                    ovf_hit_s;
    logic                    unf_hit_s;

    // Net the effective deltas, saturate to 0..CAPACITY and flag errors.
    always_comb begin
        cur_s      = SUM_W'(capacity_r);
        w_s        = {SUM_W{1'b0}};
        r_s        = {SUM_W{1'b0}};
        next_cap_s = {CW{1'b0}};
        ovf_hit_s  = 1'b0;
        unf_hit_s  = 1'b0;
        if (write_enable) begin
            w_s = SUM_W'(write_count);
        end else begin
            w_s = {SUM_W{1'b0}};
        end
        if (read_enable) begin
            r_s = SUM_W'(read_count);
        end else begin
            r_s = {SUM_W{1'b0}};
        end
        sum_s = cur_s + w_s - r_s;
        if (clear) begin
            next_cap_s = {CW{1'b0}};
        end else if (sum_s > CAP_SUM) begin
            next_cap_s = CAP_L;
            ovf_hit_s  = 1'b1;
        end else if (sum_s[SUM_W-1]) begin
            next_cap_s = {CW{1'b0}};
            unf_hit_s  = 1'b1;
        end else begin
            next_cap_s = sum_s[CW-1:0];
        end
    end

    // Occupancy, flags derived from the next value, and sticky errors (set wins).
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            capacity_r     <= {CW{1'b0}};
            free_r         <= CAP_L;
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_empty_r <= 1'b1;
            almost_full_r  <= AF_RESET;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            capacity_r     <= next_cap_s;
            free_r         <= CAP_L - next_cap_s;
            empty_r        <= (next_cap_s == {CW{1'b0}});
            full_r         <= (next_cap_s == CAP_L);
            almost_empty_r <= (next_cap_s <= AE_L);
            almost_full_r  <= (next_cap_s >= AF_L);
            overflow_r     <= ovf_hit_s || (overflow_r && !error_clear);
            underflow_r    <= unf_hit_s || (underflow_r && !error_clear);
        end
    end

    assign capacity     = capacity_r;
    assign free         = free_r;
    assign empty        = empty_r;
    assign full         = full_r;
    assign almost_empty = almost_empty_r;
    assign almost_full  = almost_full_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
